keypad_key_receiver: RTL and testbench

- Consumer end of the keypad scanner's done/ack handshake.
- Samples the scanner's {rows,cols} code word when done=1, then raises ack to release the scanner.
- Decodes the one-hot row and column into a binary key index and queues it in a small FIFO.
- Presents keys to the calculator core on a valid/ready interface; malformed codes (multi-key or no-key) are acknowledged, dropped and flagged.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/key_fifo.sv | 58 +++++
 rtl/keypad_key_receiver.sv | 106 ++++++++++
 tb/tb_keypad_key_receiver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the keypad receive path: receiver FSM states,
// key code width and one-hot decoding helpers.
package calc_pkg;

    typedef enum logic {IDLE, ACK} rx_state_e;

    // Width of a binary key index for a rows_count x cols_count keypad.
    function automatic int key_code_width(input int rows_count, input int cols_count);
        return $clog2(rows_count * cols_count);
    endfunction

    // Bit position of the set bit in a one-hot vector (LSB is index 0).
    function automatic int onehot_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rdata.
// Pushes while full and pops while empty are ignored.
module key_fifo #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [width-1:0]               wdata,
    output logic [width-1:0]               rdata,
    output logic [$clog2(depth+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == cw'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage, power-of-two wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_key_receiver.sv
// Consumer side of the scanner done/ack handshake. Takes one code word per
// press, decodes the one-hot row/column pair into a key index and queues it
// for the calculator core. Malformed codes are acknowledged but dropped.
module keypad_key_receiver
    import calc_pkg::*;
#(
    parameter int rows_count = 4,
    parameter int cols_count = 4,
    parameter int fifo_depth = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [rows_count+cols_count-1:0]                     data,
    input  logic                                                 done,
    output logic                                                 ack,
    output logic [key_code_width(rows_count, cols_count)-1:0]    key_code,
    output logic                                                 key_valid,
    input  logic                                                 key_ready,
    output logic                                                 invalid_key,
    output logic                                                 fifo_full
);

    localparam int kw = key_code_width(rows_count, cols_count);
    localparam int cw = $clog2(fifo_depth + 1);

    rx_state_e        state;
    rx_state_e        next_state;
    logic [rows_count-1:0] rows_field;
    logic [cols_count-1:0] cols_field;
    logic             decode_valid;
    logic [kw-1:0]    key_index;
    logic             room;
    logic             accept;
    logic             push;
    logic             ack_next;
    logic             invalid_next;
    logic [cw-1:0]    fifo_count;
    logic             fifo_empty;

    assign rows_field = data[rows_count+cols_count-1:cols_count];
    assign cols_field = data[cols_count-1:0];

    // Space is judged on the registered count only, so a same-cycle pop
    // does not let a press in until the following edge.
    assign room      = (fifo_count < cw'(fifo_depth));
    assign accept    = (state == IDLE) && done && room;
    assign key_valid = !fifo_empty;

    // Decode the code word: both fields must be one-hot to name a single key.
    always_comb begin
        decode_valid = is_onehot(32'(rows_field)) && is_onehot(32'(cols_field));
        key_index    = kw'(onehot_index(32'(rows_field)) * cols_count
                           + onehot_index(32'(cols_field)));
    end

    // State register together with the registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ack         <= 1'b0;
            invalid_key <= 1'b0;
        end else begin
            state       <= next_state;
            ack         <= ack_next;
            invalid_key <= invalid_next;
        end
    end

    // Next state: sample once per press, then wait for the scanner to drop done.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACK;
            ACK:     if (!done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: push good keys, flag bad ones, hold ack while in ACK.
    always_comb begin
        push         = accept && decode_valid;
        invalid_next = accept && !decode_valid;
        ack_next     = 1'b0;
        case (state)
            IDLE:    ack_next = accept;
            ACK:     ack_next = done;
            default: ack_next = 1'b0;
        endcase
    end

    key_fifo #(
        .width (kw),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (key_ready),
        .wdata (key_index),
        .rdata (key_code),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_keypad_key_receiver.sv
// Bench for keypad_key_receiver: directed handshake scenarios with literal
// expectations, then randomized traffic compared against a queue-based model.
module tb_keypad_key_receiver;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       done;
    logic       key_ready;
    logic       ack;
    logic [3:0] key_code;
    logic       key_valid;
    logic       invalid_key;
    logic       fifo_full;

    int vectors     = 0;
    int miscompares = 0;

    int model_q[$];
    bit model_busy  = 1'b0;
    bit model_inv   = 1'b0;
    bit check_en    = 1'b0;

    keypad_key_receiver #(
        .rows_count (4),
        .cols_count (4),
        .fifo_depth (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .done        (done),
        .ack         (ack),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .invalid_key (invalid_key),
        .fifo_full   (fifo_full)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index of a code word, or -1 when it does not name exactly one key.
    function automatic int modelCode(input logic [7:0] d);
        logic [3:0] r;
        logic [3:0] c;
        r = d[7:4];
        c = d[3:0];
        if ($countones(r) != 1 || $countones(c) != 1) return -1;
        return $clog2(r) * 4 + $clog2(c);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs just after a rising edge; they are sampled at the next one.
    task automatic applyStimulus(input logic [7:0] d, input logic dn, input logic kr);
        @(posedge clk);
        #1;
        data      = d;
        done      = dn;
        key_ready = kr;
    endtask

    task automatic clearModel();
        model_q.delete();
        model_busy = 1'b0;
        model_inv  = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic applyReset(input string name);
        @(negedge clk);
        #1;
        rst = 1'b0;
        clearModel();
        #1;
        checkOutput({name, "_ack"},   32'(ack),         32'd0);
        checkOutput({name, "_valid"}, 32'(key_valid),   32'd0);
        checkOutput({name, "_full"},  32'(fifo_full),   32'd0);
        checkOutput({name, "_inv"},   32'(invalid_key), 32'd0);
        done      = 1'b0;
        data      = 8'h00;
        key_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic press(input logic [7:0] d, input logic kr);
        applyStimulus(d, 1'b1, kr);
        applyStimulus(8'h00, 1'b0, kr);
    endtask

    // Reference model: one sample per press, queue of key indices, pops on ready.
    always @(posedge clk) begin : model_step
        int old_size;
        int code;
        bit do_push;
        if (rst) begin
            old_size  = model_q.size();
            do_push   = 1'b0;
            code      = 0;
            model_inv = 1'b0;
            if (!model_busy) begin
                if (done && old_size < 4) begin
                    code       = modelCode(data);
                    model_busy = 1'b1;
                    if (code < 0) model_inv = 1'b1;
                    else          do_push   = 1'b1;
                end
            end else if (!done) begin
                model_busy = 1'b0;
            end
            if (key_ready && old_size > 0) void'(model_q.pop_front());
            if (do_push) model_q.push_back(code);
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (rst && check_en) begin
            checkOutput("ack",         32'(ack),         32'(model_busy));
            checkOutput("invalid_key", 32'(invalid_key), 32'(model_inv));
            checkOutput("key_valid",   32'(key_valid),   32'(model_q.size() != 0));
            checkOutput("fifo_full",   32'(fifo_full),   32'(model_q.size() == 4));
            if (model_q.size() != 0)
                checkOutput("key_code", 32'(key_code), 32'(model_q[0]));
        end
    end

    initial begin : main
        int exp_drain[3];
        logic [3:0] r;
        logic [3:0] c;
        logic [7:0] d;

        rst       = 1'b0;
        data      = 8'h00;
        done      = 1'b0;
        key_ready = 1'b0;
        #2;
        checkOutput("reset_ack",   32'(ack),         32'd0);
        checkOutput("reset_inv",   32'(invalid_key), 32'd0);
        checkOutput("reset_valid", 32'(key_valid),   32'd0);
        checkOutput("reset_full",  32'(fifo_full),   32'd0);
        checkOutput("reset_code",  32'(key_code),    32'd0);
        #10;
        rst      = 1'b1;
        check_en = 1'b1;

        // Single key with consumer ready
        applyStimulus(8'b0100_0010, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_ack_high", 32'(ack),         32'd1);
        checkOutput("t1_valid",    32'(key_valid),   32'd1);
        checkOutput("t1_code",     32'(key_code),    32'd9);
        checkOutput("t1_inv",      32'(invalid_key), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_ack_low",  32'(ack),       32'd0);
        checkOutput("t1_popped",   32'(key_valid), 32'd0);

        // Malformed codes: multi-key and no-key
        applyStimulus(8'b0110_0010, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2_ack",      32'(ack),         32'd1);
        checkOutput("t2_inv",      32'(invalid_key), 32'd1);
        checkOutput("t2_valid",    32'(key_valid),   32'd0);
        applyStimulus(8'b0000_0010, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t2_inv_once", 32'(invalid_key), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2b_inv",     32'(invalid_key), 32'd1);
        checkOutput("t2b_valid",   32'(key_valid),   32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);

        // Corner codes
        applyStimulus(8'b0001_0001, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_code0",    32'(key_code),  32'd0);
        checkOutput("t3_valid0",   32'(key_valid), 32'd1);
        applyStimulus(8'b1000_1000, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_code15",   32'(key_code),  32'd15);
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_drained",  32'(key_valid), 32'd0);

        // Back-pressure: fill with 0,5,10,15 then hold a fifth press
        press(8'b0001_0001, 1'b0);
        press(8'b0010_0010, 1'b0);
        press(8'b0100_0100, 1'b0);
        press(8'b1000_1000, 1'b0);
        @(negedge clk);
        checkOutput("t4_full",     32'(fifo_full), 32'd1);
        checkOutput("t4_head",     32'(key_code),  32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'b0001_0010, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("t4_hold_ack", 32'(ack), 32'd0);
        end
        applyStimulus(8'b0001_0010, 1'b1, 1'b1);
        applyStimulus(8'b0001_0010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_pop_ack",  32'(ack),       32'd0);
        checkOutput("t4_pop_full", 32'(fifo_full), 32'd0);
        checkOutput("t4_pop_head", 32'(key_code),  32'd5);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_late_ack", 32'(ack),       32'd1);
        checkOutput("t4_refull",   32'(fifo_full), 32'd1);
        checkOutput("t4_drain0",   32'(key_code),  32'd5);
        key_ready = 1'b1;
        exp_drain = '{10, 15, 1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4_drain", 32'(key_code), 32'(exp_drain[i]));
        end
        @(negedge clk);
        checkOutput("t4_empty", 32'(key_valid), 32'd0);
        key_ready = 1'b0;

        // Done held high after ack
        applyStimulus(8'b0010_1000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'b0010_1000, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("t5_ack_held", 32'(ack), 32'd1);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_ack_still", 32'(ack), 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_ack_fell", 32'(ack),       32'd0);
        checkOutput("t5_code",     32'(key_code),  32'd7);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_one_push", 32'(key_valid), 32'd0);

        // Reset while in ACK with a full queue
        press(8'b0100_0010, 1'b0);
        press(8'b0001_1000, 1'b0);
        press(8'b1000_0001, 1'b0);
        applyStimulus(8'b0010_0100, 1'b1, 1'b0);
        applyStimulus(8'b0010_0100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t6_pre_ack",  32'(ack),       32'd1);
        checkOutput("t6_pre_full", 32'(fifo_full), 32'd1);
        applyReset("t6_rst");
        applyStimulus(8'b0100_0010, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t6_post_ack",  32'(ack),      32'd1);
        checkOutput("t6_post_code", 32'(key_code), 32'd9);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (i == 400) applyReset("rand_rst");
            if ($urandom_range(0, 3) != 0) begin
                r = 4'b0001 << $urandom_range(0, 3);
                c = 4'b0001 << $urandom_range(0, 3);
                d = {r, c};
            end else begin
                d = 8'($urandom);
            end
            applyStimulus(d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 8; i++) applyStimulus(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
